l1_ahb_in_hold_stage: RTL and testbench

L1_AHB_IN_HOLD_STAGE -- requirements
Module: l1_ahb_in_hold_stage

---
 rtl/l1_ahb_in_hold_stage.sv | 103 ++++++++++
 tb/tb_l1_ahb_in_hold_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1_ahb_in_hold_stage.sv
// AHB input-port hold stage: passes transfers straight to the decoder, or parks one until the target output stage is granted.
// Optional build macro: L1_AHB_IN_HOLD_SEQ2NSEQ_EN presents a held SEQ transfer to the decoder as NONSEQ.
module l1_ahb_in_hold_stage (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic        HREADYS,
  input  logic        active_dec,
  input  logic        readyout_dec,
  input  logic [1:0]  resp_dec,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS,
  output logic        sel_dec,
  output logic [31:0] addr_dec,
  output logic [1:0]  trans_dec,
  output logic        write_dec,
  output logic [2:0]  size_dec,
  output logic        ready_dec
);

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TRANS_W = 2;
  localparam int unsigned SIZE_W  = 3;

  typedef enum logic {
    PASS = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [TRANS_W-1:0]   trans_q;
  logic                 write_q;
  logic [SIZE_W-1:0]    size_q;
  logic                 vt;
  logic                 load;
  logic [TRANS_W-1:0]   held_trans;

  assign vt   = HSELS & HTRANSS[1] & HREADYS;
  assign load = (state_q == PASS) & vt & ~active_dec;

`ifdef L1_AHB_IN_HOLD_SEQ2NSEQ_EN
  // A held burst beat loses its predecessor at the decoder, so restart it as NONSEQ.
  assign held_trans = (trans_q == 2'b11) ? 2'b10 : trans_q;
`else
  assign held_trans = trans_q;
`endif

  // State and holding registers; holding registers load only on entry to HOLD.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= PASS;
      addr_q  <= '0;
      trans_q <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        addr_q  <= HADDRS;
        trans_q <= HTRANSS;
        write_q <= HWRITES;
        size_q  <= HSIZES;
      end
    end
  end

  // Next state and output muxing between live master inputs and the held transfer.
  always_comb begin
    state_d    = state_q;
    sel_dec    = HSELS;
    addr_dec   = HADDRS;
    trans_dec  = HTRANSS;
    write_dec  = HWRITES;
    size_dec   = HSIZES;
    ready_dec  = HREADYS;
    HREADYOUTS = readyout_dec;
    HRESPS     = resp_dec;
    case (state_q)
      PASS: begin
        if (vt && !active_dec) state_d = HOLD;
      end
      HOLD: begin
        sel_dec    = 1'b1;
        addr_dec   = addr_q;
        trans_dec  = held_trans;
        write_dec  = write_q;
        size_dec   = size_q;
        ready_dec  = active_dec;
        HREADYOUTS = 1'b0;
        HRESPS     = 2'b00;
        if (active_dec) state_d = PASS;
      end
      default: state_d = PASS;
    endcase
  end

endmodule

// File: tb/tb_l1_ahb_in_hold_stage.sv
// Directed bench for l1_ahb_in_hold_stage: pass-through, hold/release, reset mid-hold, BUSY, ERROR ordering.
module tb_l1_ahb_in_hold_stage;

  logic        HCLK;
  logic        HRESET;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic        HREADYS;
  logic        active_dec;
  logic        readyout_dec;
  logic [1:0]  resp_dec;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
  logic        sel_dec;
  logic [31:0] addr_dec;
  logic [1:0]  trans_dec;
  logic        write_dec;
  logic [2:0]  size_dec;
  logic        ready_dec;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_held_seq;

  l1_ahb_in_hold_stage dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HSELS        (HSELS),
    .HADDRS       (HADDRS),
    .HTRANSS      (HTRANSS),
    .HWRITES      (HWRITES),
    .HSIZES       (HSIZES),
    .HREADYS      (HREADYS),
    .active_dec   (active_dec),
    .readyout_dec (readyout_dec),
    .resp_dec     (resp_dec),
    .HREADYOUTS   (HREADYOUTS),
    .HRESPS       (HRESPS),
    .sel_dec      (sel_dec),
    .addr_dec     (addr_dec),
    .trans_dec    (trans_dec),
    .write_dec    (write_dec),
    .size_dec     (size_dec),
    .ready_dec    (ready_dec)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and outputs checked mid-cycle.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic wr, input logic rdy, input logic act);
    HSELS      = sel;
    HTRANSS    = trans;
    HADDRS     = addr;
    HWRITES    = wr;
    HSIZES     = 3'd2;
    HREADYS    = rdy;
    active_dec = act;
  endtask

  initial begin
`ifdef L1_AHB_IN_HOLD_SEQ2NSEQ_EN
    exp_held_seq = 2'b10;
`else
    exp_held_seq = 2'b11;
`endif
    HRESET = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
    readyout_dec = 1'b1;
    resp_dec     = 2'b00;
    tick();
    tick();
    HRESET = 1'b0;
    #1;
    chk("rst_readyout", 32'(HREADYOUTS), 32'd1);
    chk("rst_resp", 32'(HRESPS), 32'd0);
    chk("rst_sel", 32'(sel_dec), 32'd0);
    readyout_dec = 1'b0;
    resp_dec     = 2'b01;
    #1;
    chk("rst_follow_readyout", 32'(HREADYOUTS), 32'd0);
    chk("rst_follow_resp", 32'(HRESPS), 32'd1);

    // Granted NONSEQ read passes straight through.
    tick();
    readyout_dec = 1'b1;
    resp_dec     = 2'b00;
    drive(1'b1, 2'b10, 32'h0000_1000, 1'b0, 1'b1, 1'b1);
    #1;
    chk("pt_sel", 32'(sel_dec), 32'd1);
    chk("pt_addr", addr_dec, 32'h0000_1000);
    chk("pt_ready", 32'(ready_dec), 32'd1);
    chk("pt_trans", 32'(trans_dec), 32'd2);
    chk("pt_hreadyout", 32'(HREADYOUTS), 32'd1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("pt_stay_pass", 32'(HREADYOUTS), 32'd1);
    chk("pt_idle_sel", 32'(sel_dec), 32'd0);

    // Ungranted NONSEQ write held three cycles; master inputs wander meanwhile.
    tick();
    drive(1'b1, 2'b10, 32'h0000_2004, 1'b1, 1'b1, 1'b0);
    #1;
    chk("h_c0_hreadyout", 32'(HREADYOUTS), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b0, 2'b11, 32'hDEAD_BEEF, 1'b0, 1'b1, (i == 2));
      resp_dec = 2'b01;
      #1;
      chk("h_hreadyout", 32'(HREADYOUTS), 32'd0);
      chk("h_resp", 32'(HRESPS), 32'd0);
      chk("h_addr", addr_dec, 32'h0000_2004);
      chk("h_write", 32'(write_dec), 32'd1);
      chk("h_sel", 32'(sel_dec), 32'd1);
      chk("h_trans", 32'(trans_dec), 32'd2);
      chk("h_size", 32'(size_dec), 32'd2);
      chk("h_ready", 32'(ready_dec), (i == 2) ? 32'd1 : 32'd0);
    end
    tick();
    resp_dec = 2'b00;
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("h_release_hreadyout", 32'(HREADYOUTS), 32'd1);
    chk("h_release_sel", 32'(sel_dec), 32'd0);

    // Held SEQ: passes through untouched, converted only when held and the macro is on.
    tick();
    drive(1'b1, 2'b11, 32'h0000_0008, 1'b0, 1'b1, 1'b0);
    #1;
    chk("seq_pt_trans", 32'(trans_dec), 32'd3);
    tick();
    drive(1'b1, 2'b10, 32'h0000_9000, 1'b0, 1'b1, 1'b1);
    #1;
    chk("seq_held_trans", 32'(trans_dec), 32'(exp_held_seq));
    chk("seq_held_addr", addr_dec, 32'h0000_0008);
    chk("seq_held_ready", 32'(ready_dec), 32'd1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("seq_release", 32'(HREADYOUTS), 32'd1);

    // Reset in the middle of a hold discards the held transfer.
    tick();
    drive(1'b1, 2'b10, 32'h0000_3000, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("rh_in_hold", 32'(HREADYOUTS), 32'd0);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    #1;
    chk("rh_pass", 32'(HREADYOUTS), 32'd1);
    chk("rh_sel", 32'(sel_dec), 32'd0);
    readyout_dec = 1'b0;
    #1;
    chk("rh_follow", 32'(HREADYOUTS), 32'd0);
    readyout_dec = 1'b1;

    // BUSY is never held.
    tick();
    drive(1'b1, 2'b01, 32'h0000_5000, 1'b0, 1'b1, 1'b0);
    #1;
    chk("busy_now", 32'(HREADYOUTS), 32'd1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("busy_no_hold", 32'(HREADYOUTS), 32'd1);

    // Two-cycle ERROR completes before a following NONSEQ is held.
    tick();
    drive(1'b1, 2'b10, 32'h0000_4000, 1'b0, 1'b0, 1'b0);
    readyout_dec = 1'b0;
    resp_dec     = 2'b01;
    #1;
    chk("err1_resp", 32'(HRESPS), 32'd1);
    chk("err1_hreadyout", 32'(HREADYOUTS), 32'd0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
    readyout_dec = 1'b1;
    #1;
    chk("err2_resp", 32'(HRESPS), 32'd1);
    chk("err2_hreadyout", 32'(HREADYOUTS), 32'd1);
    tick();
    resp_dec = 2'b00;
    drive(1'b1, 2'b10, 32'h0000_4000, 1'b0, 1'b1, 1'b0);
    #1;
    chk("err_after_pass", 32'(HREADYOUTS), 32'd1);
    chk("err_after_resp", 32'(HRESPS), 32'd0);
    tick();
    drive(1'b1, 2'b10, 32'h0000_4000, 1'b0, 1'b1, 1'b1);
    #1;
    chk("err_then_hold", 32'(HREADYOUTS), 32'd0);
    chk("err_then_addr", addr_dec, 32'h0000_4000);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("err_final_pass", 32'(HREADYOUTS), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
